// File: rtl/mips8_mem_alu_core.sv
// ---------------------------------------------------------------------------
// mips8_mem_alu_core
//
// Memory/execute slice of the 8-bit single-cycle MIPS-style processor.
// It sits between fetch/register-file logic and the write-back mux, and
// holds three parts:
//   - Mips8InstrMem : program store. Combinational fetch, synchronous
//                     program load. The program survives reset.
//   - Mips8Alu      : 2-bit controlled ADD/SUB/AND/OR with a zero flag.
//   - Mips8DataMem  : data store addressed by the ALU result.
//                     Combinational read, synchronous write. Reset clears
//                     it asynchronously.
//
// Ports (top):
//   clk, rst_n                 clock; asynchronous active-low reset
//   im_cs_n, im_oe, im_addr    instruction fetch controls and PC address
//   im_data                    fetched instruction (0 when not enabled)
//   prog_we/addr/data          instruction memory program-load port
//   alu_ctrl, alu_a, alu_b     ALU op select and operands
//   alu_out, zero              ALU result (also DM address) and zero flag
//   dm_we, dm_wdata            data memory write enable and write data
//   dm_rdata                   data memory read data at alu_out
//
// No output is registered. Every output path is combinational.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// Mips8Alu
// Purely combinational ALU.
//   ctrl   : 00 add, 01 sub, 10 and, 11 or
//   a, b   : operands
//   result : result, modulo 2**DATA_W
//   zero   : high when result is zero
// ---------------------------------------------------------------------------
module Mips8Alu #(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } aluOp_t;

  aluOp_t op;

  assign op = aluOp_t'(ctrl);

  // Operation select. Carry and borrow fall off the top because the result
  // is the same width as the operands. That is the intended wrap-around
  // behaviour, and there is no overflow flag.
  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

  // The zero flag follows the result for every op, not only for subtract.
  assign zero = (result == '0);

endmodule

// ---------------------------------------------------------------------------
// Mips8InstrMem
// Instruction store.
//   clk                          program-load clock
//   csN, oe                      fetch enables (active-low select, active-high OE)
//   addr, rdata                  fetch address and instruction
//   progWe, progAddr, progData   program-load write port
// The array starts at zero and has no reset, so a loaded program stays
// intact across rst_n pulses.
// ---------------------------------------------------------------------------
module Mips8InstrMem #(
  parameter int IM_DATA_W = 8,
  parameter int IM_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 csN,
  input  logic                 oe,
  input  logic [IM_ADDR_W-1:0] addr,
  output logic [IM_DATA_W-1:0] rdata,
  input  logic                 progWe,
  input  logic [IM_ADDR_W-1:0] progAddr,
  input  logic [IM_DATA_W-1:0] progData
);

  localparam int IM_DEPTH = 1 << IM_ADDR_W;

  // Unwritten locations must read as zero. The array therefore carries a
  // zero initialiser instead of a reset.
  logic [IM_DATA_W-1:0] imMem [IM_DEPTH] = '{default: '0};

  // Program load. A fetch of the location being loaded still sees the old
  // word until this edge commits the new one.
  always_ff @(posedge clk) begin
    if (progWe) begin
      imMem[progAddr] <= progData;
    end
  end

  // Fetch drives zero rather than floating when it is not enabled. This
  // keeps the bus a plain mux and avoids tristates.
  assign rdata = (!csN && oe) ? imMem[addr] : '0;

endmodule

// ---------------------------------------------------------------------------
// Mips8DataMem
// Data store.
//   clk, rst_n   clock; asynchronous active-low clear of every word
//   addr         word address (low bits of the ALU result)
//   we, wdata    synchronous write port
//   rdata        combinational read of mem[addr]
// ---------------------------------------------------------------------------
module Mips8DataMem #(
  parameter int DATA_W    = 8,
  parameter int DM_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DM_ADDR_W-1:0] addr,
  input  logic                 we,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DM_DEPTH = 1 << DM_ADDR_W;

  logic [DATA_W-1:0] dmMem [DM_DEPTH];

  // While rst_n is low, every word is held at zero and writes are ignored.
  // Leaving reset needs no special handling: the first rising edge with
  // rst_n high is already a normal write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DM_DEPTH; i++) begin
        dmMem[i] <= '0;
      end
    end else if (we) begin
      dmMem[addr] <= wdata;
    end
  end

  // Reads are always enabled. A read of the address being written shows the
  // old data until the edge.
  assign rdata = dmMem[addr];

endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module mips8_mem_alu_core #(
  parameter int DATA_W    = 8,
  parameter int DM_ADDR_W = 8,
  parameter int IM_DATA_W = 8,
  parameter int IM_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 im_cs_n,
  input  logic                 im_oe,
  input  logic [IM_ADDR_W-1:0] im_addr,
  output logic [IM_DATA_W-1:0] im_data,
  input  logic                 prog_we,
  input  logic [IM_ADDR_W-1:0] prog_addr,
  input  logic [IM_DATA_W-1:0] prog_data,
  input  logic [1:0]           alu_ctrl,
  input  logic [DATA_W-1:0]    alu_a,
  input  logic [DATA_W-1:0]    alu_b,
  output logic [DATA_W-1:0]    alu_out,
  output logic                 zero,
  input  logic                 dm_we,
  input  logic [DATA_W-1:0]    dm_wdata,
  output logic [DATA_W-1:0]    dm_rdata
);

  // The DM address is a slice of the ALU result, so it cannot be wider.
  if (DM_ADDR_W > DATA_W) begin : gBadDmAddrW
    $error("DM_ADDR_W must not exceed DATA_W");
  end

  logic [DM_ADDR_W-1:0] dmAddr;

  // Addresses wrap naturally. For example, 0 - 1 = 8'hFF selects the last
  // word, and no range check is needed.
  assign dmAddr = alu_out[DM_ADDR_W-1:0];

  Mips8InstrMem #(
    .IM_DATA_W (IM_DATA_W),
    .IM_ADDR_W (IM_ADDR_W)
  ) uInstrMem (
    .clk      (clk),
    .csN      (im_cs_n),
    .oe       (im_oe),
    .addr     (im_addr),
    .rdata    (im_data),
    .progWe   (prog_we),
    .progAddr (prog_addr),
    .progData (prog_data)
  );

  Mips8Alu #(
    .DATA_W (DATA_W)
  ) uAlu (
    .ctrl   (alu_ctrl),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_out),
    .zero   (zero)
  );

  Mips8DataMem #(
    .DATA_W    (DATA_W),
    .DM_ADDR_W (DM_ADDR_W)
  ) uDataMem (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (dmAddr),
    .we    (dm_we),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

endmodule

// File: tb/tb_mips8_mem_alu_core.sv
// ---------------------------------------------------------------------------
// tb_mips8_mem_alu_core
// Scoreboard bench for mips8_mem_alu_core. The stimulus process pushes
// hand-computed expected values into a queue and then raises a sample
// event. The monitor process pops every queued item on that event and
// compares it with the live DUT output the item names.
// ---------------------------------------------------------------------------
module tb_mips8_mem_alu_core;

  logic       clk;
  logic       rst_n;
  logic       im_cs_n;
  logic       im_oe;
  logic [7:0] im_addr;
  logic [7:0] im_data;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic [1:0] alu_ctrl;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       zero;
  logic       dm_we;
  logic [7:0] dm_wdata;
  logic [7:0] dm_rdata;

  localparam int SEL_ALU  = 0;
  localparam int SEL_ZERO = 1;
  localparam int SEL_IM   = 2;
  localparam int SEL_DM   = 3;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } expItem_t;

  expItem_t expQ[$];
  event     sampleEv;
  int       errors = 0;
  int       checks = 0;

  mips8_mem_alu_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .im_cs_n   (im_cs_n),
    .im_oe     (im_oe),
    .im_addr   (im_addr),
    .im_data   (im_data),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .zero      (zero),
    .dm_we     (dm_we),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata)
  );

  // 10 ns clock with the first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: on each sample event, drain the queue against the DUT outputs.
  initial begin
    expItem_t   item;
    logic [7:0] act;
    forever begin
      @(sampleEv);
      while (expQ.size() > 0) begin
        item = expQ.pop_front();
        case (item.sel)
          SEL_ALU:  act = alu_out;
          SEL_ZERO: act = {7'b0, zero};
          SEL_IM:   act = im_data;
          default:  act = dm_rdata;
        endcase
        checks++;
        if (act !== item.exp) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", item.name, act, item.exp);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] ctrl, input logic [7:0] a,
                               input logic [7:0] b, input logic we,
                               input logic [7:0] wdata);
    alu_ctrl = ctrl;
    alu_a    = a;
    alu_b    = b;
    dm_we    = we;
    dm_wdata = wdata;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [7:0] exp);
    expItem_t item;
    item.name = name;
    item.sel  = sel;
    item.exp  = exp;
    expQ.push_back(item);
  endtask

  // Let the inputs settle away from any clock edge, then hand the queued
  // expectations to the monitor.
  task automatic present();
    #1;
    -> sampleEv;
    #1;
  endtask

  // Move past the next rising edge, well clear of it.
  task automatic passEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    im_cs_n   = 1'b1;
    im_oe     = 1'b0;
    im_addr   = 8'h00;
    prog_we   = 1'b0;
    prog_addr = 8'h00;
    prog_data = 8'h00;
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 8'h00);

    // Reset state
    #2;
    checkOutput("reset_dm_rdata", SEL_DM, 8'h00);
    checkOutput("reset_im_data", SEL_IM, 8'h00);
    checkOutput("reset_zero", SEL_ZERO, 8'h01);
    present();
    @(negedge clk);
    rst_n = 1'b1;

    // ALU ops
    applyStimulus(2'b00, 8'h7F, 8'h01, 1'b0, 8'h00);
    checkOutput("add_7f_01", SEL_ALU, 8'h80);
    checkOutput("add_7f_01_zero", SEL_ZERO, 8'h00);
    present();
    applyStimulus(2'b00, 8'hFF, 8'h01, 1'b0, 8'h00);
    checkOutput("add_ff_01", SEL_ALU, 8'h00);
    checkOutput("add_ff_01_zero", SEL_ZERO, 8'h01);
    present();
    applyStimulus(2'b01, 8'h05, 8'h05, 1'b0, 8'h00);
    checkOutput("sub_5_5", SEL_ALU, 8'h00);
    checkOutput("sub_5_5_zero", SEL_ZERO, 8'h01);
    present();
    applyStimulus(2'b01, 8'h00, 8'h01, 1'b0, 8'h00);
    checkOutput("sub_0_1", SEL_ALU, 8'hFF);
    checkOutput("sub_0_1_zero", SEL_ZERO, 8'h00);
    present();
    applyStimulus(2'b10, 8'hF0, 8'h3C, 1'b0, 8'h00);
    checkOutput("and_f0_3c", SEL_ALU, 8'h30);
    present();
    applyStimulus(2'b11, 8'hF0, 8'h0F, 1'b0, 8'h00);
    checkOutput("or_f0_0f", SEL_ALU, 8'hFF);
    present();
    applyStimulus(2'b10, 8'hF0, 8'h0F, 1'b0, 8'h00);
    checkOutput("and_f0_0f_zero", SEL_ZERO, 8'h01);
    present();

    // IM load and fetch
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 8'h03;
    prog_data = 8'hA5;
    im_addr   = 8'h03;
    im_cs_n   = 1'b0;
    im_oe     = 1'b1;
    checkOutput("im_old_before_edge", SEL_IM, 8'h00);
    present();
    passEdge();
    prog_we = 1'b0;
    checkOutput("im_fetch_a5", SEL_IM, 8'hA5);
    present();
    im_cs_n = 1'b1;
    checkOutput("im_cs_off", SEL_IM, 8'h00);
    present();
    im_cs_n = 1'b0;
    im_oe   = 1'b0;
    checkOutput("im_oe_off", SEL_IM, 8'h00);
    present();
    im_oe = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    checkOutput("im_survives_reset", SEL_IM, 8'hA5);
    present();

    // DM store and load
    @(negedge clk);
    applyStimulus(2'b00, 8'h10, 8'h02, 1'b1, 8'h5A);
    checkOutput("dm_store_addr", SEL_ALU, 8'h12);
    present();
    passEdge();
    dm_we = 1'b0;
    checkOutput("dm_load_12", SEL_DM, 8'h5A);
    present();
    applyStimulus(2'b00, 8'h10, 8'h01, 1'b0, 8'h00);
    checkOutput("dm_load_11", SEL_DM, 8'h00);
    present();
    applyStimulus(2'b00, 8'h10, 8'h02, 1'b0, 8'h00);

    // Async reset mid-operation, between edges
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    checkOutput("dm_async_clear", SEL_DM, 8'h00);
    present();
    applyStimulus(2'b00, 8'h10, 8'h02, 1'b1, 8'h77);
    passEdge();
    checkOutput("dm_write_blocked", SEL_DM, 8'h00);
    present();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 8'h10, 8'h02, 1'b1, 8'h99);
    checkOutput("dm_release_pre_edge", SEL_DM, 8'h00);
    present();
    passEdge();
    dm_we = 1'b0;
    checkOutput("dm_first_write", SEL_DM, 8'h99);
    present();

    // Address wrap
    @(negedge clk);
    applyStimulus(2'b01, 8'h00, 8'h01, 1'b1, 8'hC3);
    passEdge();
    dm_we = 1'b0;
    checkOutput("wrap_addr", SEL_ALU, 8'hFF);
    checkOutput("wrap_load_ff", SEL_DM, 8'hC3);
    present();
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
    checkOutput("wrap_addr0_untouched", SEL_DM, 8'h00);
    present();

    // Same-cycle read of the location being written
    @(negedge clk);
    applyStimulus(2'b00, 8'h04, 8'h00, 1'b1, 8'h11);
    checkOutput("same_cycle_old", SEL_DM, 8'h00);
    present();
    passEdge();
    dm_we = 1'b0;
    checkOutput("same_cycle_new", SEL_DM, 8'h11);
    present();

    // Simultaneous IM program load and DM store
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 8'h05;
    prog_data = 8'h3C;
    applyStimulus(2'b00, 8'h04, 8'h00, 1'b1, 8'h22);
    passEdge();
    prog_we = 1'b0;
    dm_we   = 1'b0;
    im_addr = 8'h05;
    checkOutput("simul_im", SEL_IM, 8'h3C);
    checkOutput("simul_dm", SEL_DM, 8'h22);
    present();
    im_addr = 8'h03;
    checkOutput("simul_im_other", SEL_IM, 8'hA5);
    applyStimulus(2'b00, 8'h05, 8'h00, 1'b0, 8'h00);
    checkOutput("simul_dm_other", SEL_DM, 8'h00);
    present();

    #2;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips8_mem_alu_core.md
Name: mips8_mem_alu_core

Overview:
- Memory/execute core of the 8-bit single-cycle MIPS-style processor.
- Contains three parts:
  - an instruction memory (IM) read by the PC;
  - a 2-bit-controlled ALU with zero flag;
  - a data memory (DM) addressed by the ALU result.
- Sits between fetch/register-file logic and the write-back mux.
- Reads are combinational; writes are synchronous to clk.

Parameters:
- DATA_W, 8, ALU operand/result width and DM word width.
- DM_ADDR_W, 8, DM address width; depth 2**DM_ADDR_W. Must be <= DATA_W.
- IM_DATA_W, 8, instruction word width.
- IM_ADDR_W, 8, IM address width; depth 2**IM_ADDR_W.

Ports:
- clk  in  1  Single clock; all writes on rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- im_cs_n  in  1  IM chip select, active low.
- im_oe  in  1  IM output enable, active high.
- im_addr  in  IM_ADDR_W  Instruction fetch address (from PC).
- im_data  out  IM_DATA_W  Fetched instruction.
- prog_we  in  1  IM program-load write enable.
- prog_addr  in  IM_ADDR_W  IM program-load address.
- prog_data  in  IM_DATA_W  IM program-load data.
- alu_ctrl  in  2  ALU operation select.
- alu_a  in  DATA_W  Operand A (register read data 1, or 0 for load-immediate).
- alu_b  in  DATA_W  Operand B (register read data 2 or extended immediate).
- alu_out  out  DATA_W  ALU result; also the DM address.
- zero  out  1  High when alu_out == 0.
- dm_we  in  1  DM write enable.
- dm_wdata  in  DATA_W  DM write data (register read data 2).
- dm_rdata  out  DATA_W  DM read data at address alu_out.

Behaviour:
- ALU, combinational:
  - 00 ADD: a+b.
  - 01 SUB: a−b.
  - 10 AND: a&b.
  - 11 OR: a|b.
  - Results are modulo 2**DATA_W; carry/borrow discarded, no overflow flag.
  - zero = (alu_out == 0), recomputed combinationally for every op.
- IM:
  - Array of 2**IM_ADDR_W words.
  - im_data = mem[im_addr] combinationally when im_cs_n==0 and im_oe==1; otherwise im_data = 0 (no tristate).
  - prog_we writes prog_data to mem[prog_addr] on rising clk.
  - Reading the location being written in the same cycle returns the old value until the edge.
  - IM contents are NOT affected by rst_n: the program survives reset.
  - Locations never written read as 0; initialise the array to 0 at elaboration.
- DM:
  - Array of 2**DM_ADDR_W words; dm_addr = alu_out[DM_ADDR_W-1:0].
  - dm_rdata = mem[dm_addr] combinationally, always enabled.
  - dm_we==1 at rising clk: mem[dm_addr] <= dm_wdata.
  - Read of the just-written address shows new data after the edge (write-then-read next cycle); same-cycle read shows old data.
  - rst_n low asynchronously clears all DM words to 0 and blocks writes for as long as it is held.
  - Release of rst_n is synchronous to the next rising edge: the first write can occur on the first edge with rst_n high.
- Address wrap: no range error. Addresses wrap naturally (e.g. a SUB giving 8'hFF addresses the last DM word).
- Simultaneous prog_we and dm_we act on independent arrays with no interaction.
- No outputs are registered. Reset affects only DM contents, and through them dm_rdata (0 during reset).

Test Plan:
- ALU ops:
  - ctrl=00, a=8'h7F, b=8'h01 → alu_out=8'h80, zero=0.
  - ctrl=00, a=8'hFF, b=8'h01 → 8'h00, zero=1.
  - ctrl=01, a=5, b=5 → 0, zero=1.
  - ctrl=01, a=0, b=1 → 8'hFF.
  - ctrl=10, a=8'hF0, b=8'h3C → 8'h30.
  - ctrl=11, a=8'hF0, b=8'h0F → 8'hFF.
- IM load/fetch:
  - Write prog_addr=3, data=8'hA5 with prog_we.
  - im_addr=3, cs_n=0, oe=1 → im_data=8'hA5.
  - cs_n=1 or oe=0 → im_data=0.
  - Pulse rst_n low → im_data still 8'hA5.
- DM store/load:
  - ctrl=00, a=8'h10, b=8'h02, dm_wdata=8'h5A, dm_we=1 for one edge.
  - Then dm_we=0, same address → dm_rdata=8'h5A.
  - Address 8'h11 → dm_rdata=0.
- Async reset mid-operation:
  - After the store above, drop rst_n between clock edges.
  - dm_rdata → 0 immediately, no clock needed.
  - dm_we=1 during reset leaves memory 0.
  - First write after release succeeds.
- Wrap: ctrl=01, a=0, b=1 (address 8'hFF), store 8'hC3, then read 8'hFF → 8'hC3; address 0 unchanged.
- Same-cycle: store 8'h11 to address 4; before the edge dm_rdata shows the old value (0), after the edge 8'h11.
